// File: rtl/gen_fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream port.
// The output buffer is fixed at two entries so a 1-cycle RAM can sustain full throughput.
package gen_fifo_rd_pkg;

  localparam int unsigned BUF_D     = 2;
  localparam int unsigned BUF_CNT_W = 2;

  typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

  // Two-entry ring index: 0 -> 1 -> 0.
  function automatic logic idx_inc(input logic idx);
    return (idx == 1'b1) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/gen_fifo_skid_buf.sv
// Two-entry register buffer with independent head/tail indices and an occupancy count.
// clr flushes indices and count and overrides any same-cycle push or pop.
module gen_fifo_skid_buf
  import gen_fifo_rd_pkg::*;
#(
  parameter int unsigned DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [DAT_W-1:0] push_data,
  input  logic             pop,
  output logic [DAT_W-1:0] head_data,
  output buf_cnt_t         cnt
);

  logic [DAT_W-1:0] mem_q [BUF_D];
  logic             head_q, tail_q;
  buf_cnt_t         cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_D); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !clr) begin
      mem_q[tail_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= '0;
    end else if (clr) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= idx_inc(tail_q);
      if (pop)  head_q <= idx_inc(head_q);
      cnt_q <= cnt_q + buf_cnt_t'(push) - buf_cnt_t'(pop);
    end
  end

  assign head_data = mem_q[head_q];
  assign cnt       = cnt_q;

endmodule

// File: rtl/gen_fifo_rd_port.sv
// Read-side valid/ready port for a FIFO controller plus 1-cycle-latency RAM.
// Pops are issued only when the buffer has room for the word that will return next cycle.
module gen_fifo_rd_port
  import gen_fifo_rd_pkg::buf_cnt_t;
#(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned BUF_D = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             fifo_empty,
  output logic             pop,
  input  logic [DAT_W-1:0] mem_rd_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_data,
  output logic [1:0]       sts_buf_cnt
);

  logic     inflight_q, drop_q;
  logic     deq, capture;
  buf_cnt_t buf_cnt, reserved, room_used;

  assign deq       = out_vld & out_rdy;
  assign reserved  = buf_cnt + buf_cnt_t'(inflight_q);
  // Occupancy after this cycle's dequeue; never exceeds 2 so 2-bit math cannot wrap.
  assign room_used = reserved - buf_cnt_t'(deq);
  assign pop       = ~clr & ~fifo_empty & (room_used < buf_cnt_t'(BUF_D));
  assign capture   = inflight_q & ~drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      inflight_q <= pop;
      drop_q     <= clr & inflight_q;
    end
  end

  gen_fifo_skid_buf #(
    .DAT_W (DAT_W)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (capture),
    .push_data (mem_rd_data),
    .pop       (deq),
    .head_data (out_data),
    .cnt       (buf_cnt)
  );

  assign out_vld     = (buf_cnt != '0);
  assign sts_buf_cnt = buf_cnt;

endmodule

// File: tb/tb_gen_fifo_rd_port.sv
// Bench for gen_fifo_rd_port: queue-based FIFO/RAM model feeding a scoreboard of expected words.
module tb_gen_fifo_rd_port;

  logic       clk = 1'b0;
  logic       rst_n, clr, fifo_empty, pop, out_vld, out_rdy;
  logic [7:0] mem_rd_data, out_data;
  logic [1:0] sts_buf_cnt;

  always #5 clk = ~clk;

  gen_fifo_rd_port #(
    .DAT_W (8),
    .BUF_D (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .fifo_empty  (fifo_empty),
    .pop         (pop),
    .mem_rd_data (mem_rd_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .sts_buf_cnt (sts_buf_cnt)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mem_nxt = 8'h00;
  logic [7:0] w;
  logic [7:0] prev_data;
  logic       prev_hold = 1'b0, prev_clr = 1'b0;
  int         n_chk = 0, n_err = 0, pop_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor and FIFO/RAM model: a pop removes the FIFO head, which becomes the next
  // expected output word and the RAM data of the following cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
      prev_clr  = 1'b0;
      mem_nxt   = 8'($urandom);
    end else begin
      chk("cnt_le_2", int'(sts_buf_cnt <= 2'd2), 1);
      chk("vld_vs_cnt", int'(out_vld), int'(sts_buf_cnt != 2'd0));
      if (prev_hold && !prev_clr) begin
        chk("hold_vld", int'(out_vld), 1);
        chk("hold_data", int'(out_data), int'(prev_data));
      end
      if (!clr && out_vld && out_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
      if (clr) begin
        chk("pop_in_clr", int'(pop), 0);
        exp_q.delete();
      end
      if (pop) begin
        chk("underflow", int'(fifo_empty), 0);
        pop_cnt++;
        if (fifo_q.size() != 0) begin
          w = fifo_q.pop_front();
          exp_q.push_back(w);
          mem_nxt = w;
        end
      end else begin
        mem_nxt = 8'($urandom);
      end
      prev_hold = out_vld & ~out_rdy;
      prev_data = out_data;
      prev_clr  = clr;
    end
  end

  // Registered controller status and RAM output, updated just after each edge.
  initial begin
    mem_rd_data = 8'h00;
    fifo_empty  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_data = mem_nxt;
      fifo_empty  = !rst_n || (fifo_q.size() == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !out_vld) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  int         base;
  logic [7:0] seq;

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    out_rdy = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset with an empty FIFO.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_pop", int'(pop), 0);
      chk("t1_vld", int'(out_vld), 0);
      chk("t1_data", int'(out_data), 0);
      chk("t1_cnt", int'(sts_buf_cnt), 0);
    end

    // Latency and back-to-back delivery.
    step();
    out_rdy = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    @(negedge clk); chk("t2_pop_n0", int'(pop), 1); chk("t2_vld_n0", int'(out_vld), 0);
    step();
    @(negedge clk); chk("t2_pop_n1", int'(pop), 1); chk("t2_vld_n1", int'(out_vld), 0);
    step();
    @(negedge clk); chk("t2_pop_n2", int'(pop), 1); chk("t2_d_n2", int'(out_data), 'h11);
    chk("t2_vld_n2", int'(out_vld), 1);
    step();
    @(negedge clk); chk("t2_pop_n3", int'(pop), 0); chk("t2_d_n3", int'(out_data), 'h22);
    step();
    @(negedge clk); chk("t2_d_n4", int'(out_data), 'h33); chk("t2_vld_n4", int'(out_vld), 1);
    step();
    @(negedge clk); chk("t2_vld_n5", int'(out_vld), 0);

    // Backpressure: only two words may be popped while stalled.
    step();
    out_rdy = 1'b0;
    base = pop_cnt;
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    repeat (6) step();
    @(negedge clk); #1;
    chk("t3_pops", pop_cnt - base, 2);
    chk("t3_cnt", int'(sts_buf_cnt), 2);
    chk("t3_head", int'(out_data), 'hA0);
    chk("t3_pop_stalled", int'(pop), 0);
    step();
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_nogap", int'(out_vld), 1);
    end
    drain("t3_drain", 20);

    // Alternating then random ready with a mostly continuous supply.
    seq = 8'h01;
    for (int i = 0; i < 300; i++) begin
      step();
      out_rdy = (i < 20) ? ((i % 2) == 0) : 1'($urandom);
      if (i < 20 || ($urandom % 4) != 0) begin
        push_word(seq);
        seq = seq + 8'h01;
      end
    end
    drain("t4_drain", 100);

    // clr one cycle after a pop while the buffer holds data.
    step();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    step();
    step();
    clr = 1'b1;
    fifo_q.delete();
    @(negedge clk); chk("t5_vld_pre", int'(out_vld), 1);
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("t5_vld", int'(out_vld), 0);
    chk("t5_cnt", int'(sts_buf_cnt), 0);
    step();
    for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i));
    drain("t5_drain", 30);

    // Asynchronous reset with a full buffer.
    step();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    repeat (3) step();
    chk("t6_pre_cnt", int'(sts_buf_cnt), 2);
    rst_n = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    #1;
    chk("t6_vld", int'(out_vld), 0);
    chk("t6_cnt", int'(sts_buf_cnt), 0);
    chk("t6_data", int'(out_data), 0);
    chk("t6_pop", int'(pop), 0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) push_word(8'hE0 + 8'(i));
    drain("t6_drain", 30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
